// File: rtl/demultiplexer_pkg.sv
// -----------------------------------------------------------------------------
// demultiplexer_pkg
// Shared constants for the 1-to-4 registered demultiplexer:
//   - select encodings naming which output a SEL value routes to
//   - default data width
// -----------------------------------------------------------------------------
package demultiplexer_pkg;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_SEL_W = 2;

  localparam logic [1:0] SEL_W_OUT = 2'b00;
  localparam logic [1:0] SEL_X_OUT = 2'b01;
  localparam logic [1:0] SEL_Y_OUT = 2'b10;
  localparam logic [1:0] SEL_Z_OUT = 2'b11;

  localparam int NUM_OUT = 4;

endpackage : demultiplexer_pkg

// File: rtl/demultiplexer_if.sv
// -----------------------------------------------------------------------------
// demultiplexer_if
// Bundles the routing bus of the demultiplexer: data in (a), select (sel) and
// the four routed outputs (w, x, y, z).
//   master : the source side, drives a/sel and observes w/x/y/z
//   slave  : the demultiplexer side, consumes a/sel and drives w/x/y/z
// -----------------------------------------------------------------------------
interface demultiplexer_if
  import demultiplexer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
);

  logic [WIDTH-1:0] a;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;

  modport master (
    output a,
    output sel,
    input  w,
    input  x,
    input  y,
    input  z
  );

  modport slave (
    input  a,
    input  sel,
    output w,
    output x,
    output y,
    output z
  );

endinterface : demultiplexer_if

// File: rtl/demultiplexer_decode.sv
// -----------------------------------------------------------------------------
// demux_decode
// Purely combinational select decode. Maps sel_i to a one-hot enable and gates
// a_i onto the four next-state buses; deselected buses are forced to zero.
//   a_i     : data to route
//   sel_i   : output select
//   en_o    : one-hot enable, bit n set when output n is selected
//   w_d_o .. z_d_o : next-state values for the four output registers
// -----------------------------------------------------------------------------
module demux_decode
  import demultiplexer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [NUM_OUT-1:0] en_o,
  output logic [WIDTH-1:0]   w_d_o,
  output logic [WIDTH-1:0]   x_d_o,
  output logic [WIDTH-1:0]   y_d_o,
  output logic [WIDTH-1:0]   z_d_o
);

  // An unknown select falls into default and enables nothing, so every
  // output clears rather than holding a stale value.
  always_comb begin
    en_o = '0;
    case (sel_i)
      SEL_W_OUT: en_o = 4'b0001;
      SEL_X_OUT: en_o = 4'b0010;
      SEL_Y_OUT: en_o = 4'b0100;
      SEL_Z_OUT: en_o = 4'b1000;
      default:   en_o = '0;
    endcase
  end

  assign w_d_o = en_o[0] ? a_i : '0;
  assign x_d_o = en_o[1] ? a_i : '0;
  assign y_d_o = en_o[2] ? a_i : '0;
  assign z_d_o = en_o[3] ? a_i : '0;

endmodule : demux_decode

// File: rtl/demultiplexer.sv
// -----------------------------------------------------------------------------
// demultiplexer
// 1-to-4 registered demultiplexer. A is routed to exactly one of W/X/Y/Z as
// chosen by SEL; the other three outputs are zero. All outputs are registered,
// giving one clock of latency and no combinational input-to-output path.
// Ports (order kept for existing positional instantiations):
//   W, X, Y, Z : routed outputs for SEL = 00, 01, 10, 11
//   A          : data to route
//   SEL        : output select
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, clears all outputs
// -----------------------------------------------------------------------------
module demultiplexer
  import demultiplexer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  output logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  input  logic [WIDTH-1:0] A,
  input  logic [SEL_W-1:0] SEL,
  input  logic             clk,
  input  logic             rst_n
);

  // Four outputs need exactly a 2-bit select; reject anything else at build.
  if (SEL_W != 2) begin : g_bad_sel_w
    $error("demultiplexer: SEL_W must be 2");
  end

  logic [NUM_OUT-1:0] en;
  logic [WIDTH-1:0]   w_d, x_d, y_d, z_d;
  logic [WIDTH-1:0]   w_q, x_q, y_q, z_q;

  demux_decode #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_decode (
    .a_i   (A),
    .sel_i (SEL),
    .en_o  (en),
    .w_d_o (w_d),
    .x_d_o (x_d),
    .y_d_o (y_d),
    .z_d_o (z_d)
  );

  // Output register stage: every edge reloads all four, so deselected
  // outputs clear rather than hold history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else begin
      w_q <= w_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign W = w_q;
  assign X = x_q;
  assign Y = y_q;
  assign Z = z_q;

  // The one-hot enable is informational here; fold it into a no-op use.
  logic unused_en;
  assign unused_en = ^en;

endmodule : demultiplexer

// File: tb/tb_demultiplexer.sv
module tb_demultiplexer;
  import demultiplexer_pkg::*;

  localparam int WIDTH = 2;

  typedef struct {
    logic [WIDTH-1:0] w, x, y, z;
    string            name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];

  demultiplexer_if #(.WIDTH(WIDTH), .SEL_W(2)) dif ();

  demultiplexer #(.WIDTH(WIDTH), .SEL_W(2)) dut (
    .W     (dif.w),
    .X     (dif.x),
    .Y     (dif.y),
    .Z     (dif.z),
    .A     (dif.a),
    .SEL   (dif.sel),
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [4*WIDTH-1:0] act,
                     input logic [4*WIDTH-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got WXYZ=%b required %b at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [4*WIDTH-1:0] outs();
    return {dif.w, dif.x, dif.y, dif.z};
  endfunction

  // Drive inputs at a falling edge and queue what the next rising edge must load.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [1:0] sel,
                       input logic [WIDTH-1:0] ew, input logic [WIDTH-1:0] ex,
                       input logic [WIDTH-1:0] ey, input logic [WIDTH-1:0] ez,
                       input string nm);
    exp_t e;
    dif.a   = a;
    dif.sel = sel;
    e.w = ew; e.x = ex; e.y = ey; e.z = ez; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: one cycle after each issue the registered outputs are compared.
  initial begin
    exp_t e;
    int   nz;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk(e.name, outs(), {e.w, e.x, e.y, e.z});
        nz = int'(dif.w != 0) + int'(dif.x != 0) + int'(dif.y != 0) + int'(dif.z != 0);
        n_cmp++;
        if (nz > 1) begin
          n_bad++;
          $display("FAIL onehot_%s: got %0d nonzero outputs, required <=1", e.name, nz);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Reset asserted before any clock edge
    rst_n   = 1'b0;
    dif.a   = 2'b11;
    dif.sel = 2'b10;
    #2;
    chk("reset_async", outs(), 8'b00_00_00_00);
    repeat (2) @(negedge clk);
    chk("reset_held", outs(), 8'b00_00_00_00);

    // Release and route W; outputs hold until the edge
    rst_n = 1'b1;
    issue(2'b10, SEL_W_OUT, 2'b10, 2'b00, 2'b00, 2'b00, "route_w");
    #1;
    chk("hold_before_w", outs(), 8'b00_00_00_00);

    @(negedge clk);
    issue(2'b01, SEL_X_OUT, 2'b00, 2'b01, 2'b00, 2'b00, "route_x");
    #1;
    chk("hold_before_x", outs(), 8'b10_00_00_00);

    @(negedge clk);
    issue(2'b11, SEL_Y_OUT, 2'b00, 2'b00, 2'b11, 2'b00, "route_y");
    @(negedge clk);
    issue(2'b11, SEL_Z_OUT, 2'b00, 2'b00, 2'b00, 2'b11, "route_z");
    @(negedge clk);
    issue(2'b00, SEL_Z_OUT, 2'b00, 2'b00, 2'b00, 2'b00, "zero_data");
    @(negedge clk);
    issue(2'b11, SEL_Z_OUT, 2'b00, 2'b00, 2'b00, 2'b11, "route_z_again");
    drain();

    // Mid-cycle reset while Z holds 11
    chk("z_before_reset", outs(), 8'b00_00_00_11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_midrun", outs(), 8'b00_00_00_00);
    dif.a   = 2'b10;
    dif.sel = SEL_X_OUT;
    @(negedge clk);
    chk("reset_blocks_edge", outs(), 8'b00_00_00_00);
    rst_n = 1'b1;
    issue(2'b10, SEL_X_OUT, 2'b00, 2'b10, 2'b00, 2'b00, "post_reset_x");

    // Sweep all 16 A/SEL combinations, one per cycle
    for (int a = 0; a < 4; a++) begin
      for (int s = 0; s < 4; s++) begin
        logic [WIDTH-1:0] av;
        av = WIDTH'(a);
        @(negedge clk);
        issue(av, 2'(s),
              (s == 0) ? av : 2'b00, (s == 1) ? av : 2'b00,
              (s == 2) ? av : 2'b00, (s == 3) ? av : 2'b00,
              $sformatf("sweep_a%0d_s%0d", a, s));
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_demultiplexer
